axi_ram_slave: RTL and testbench

AXI4 memory responder terminating the single-master side of the 2x1 interconnect: accepts AW/W/AR bursts from the interconnect's m00 port, stores data in an internal word-addressed RAM, and returns B and R responses echoing the request ID. One transaction at a time, no reordering; serves as the emulation memory behind the custom CPU's instruction/data masters.

---
 rtl/axi_ram_slave.sv | 172 +++++++++++++++++
 tb/tb_axi_ram_slave.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// AXI4 single-transaction memory responder: word-addressed RAM behind AW/W/B and AR/R channels.
// Optional feature macro: AXI_RAM_WRAP_BURST_EN enables true WRAP bursts (otherwise WRAP behaves as INCR).
module axi_ram_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [1:0]                fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a source holds valid and its payload stable until that edge.
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFSET     = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WRESP = 2'd2, READ = 2'd3} state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       id_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     addr_next;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [8:0]                beat_q;
  logic                      prio_write;
  logic                      grant_write;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]     mem [2**MEM_ADDR_WIDTH];
  logic                      unused_ok;

  assign unused_ok = s_axi_wlast;

  // Channel not served last wins a tie; a lone valid always wins.
  assign grant_write   = s_axi_awvalid && (!s_axi_arvalid || prio_write);
  assign s_axi_awready = (state == IDLE) && grant_write;
  assign s_axi_arready = (state == IDLE) && s_axi_arvalid && !grant_write;
  assign s_axi_wready  = (state == WRITE);
  assign s_axi_bvalid  = (state == WRESP);
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign fsm_state     = state;
  assign idx           = addr_q[MEM_ADDR_WIDTH+OFFSET-1:OFFSET];

  always_comb begin
    addr_next = addr_q + (ADDR_WIDTH'(1) << size_q);
    if (burst_q == 2'b00) begin
      addr_next = addr_q;
    end
`ifdef AXI_RAM_WRAP_BURST_EN
    else if (burst_q == 2'b10) begin
      // Wrap inside the aligned (len+1)*2^size window.
      logic [ADDR_WIDTH-1:0] mask;
      mask      = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
      addr_next = (addr_q & ~mask) | ((addr_q + (ADDR_WIDTH'(1) << size_q)) & mask);
    end
`endif
  end

  // RAM has no reset: contents survive rstn.
  always_ff @(posedge clk) begin
    if (rstn && state == WRITE && s_axi_wvalid) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      prio_write   <= 1'b1;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      s_axi_bid    <= '0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_awready) begin
            id_q       <= s_axi_awid;
            addr_q     <= s_axi_awaddr;
            len_q      <= s_axi_awlen;
            size_q     <= s_axi_awsize;
            burst_q    <= s_axi_awburst;
            beat_q     <= '0;
            prio_write <= 1'b0;
            state      <= WRITE;
          end else if (s_axi_arready) begin
            id_q       <= s_axi_arid;
            s_axi_rid  <= s_axi_arid;
            addr_q     <= s_axi_araddr;
            len_q      <= s_axi_arlen;
            size_q     <= s_axi_arsize;
            burst_q    <= s_axi_arburst;
            beat_q     <= '0;
            prio_write <= 1'b1;
            state      <= READ;
          end
        end
        WRITE: begin
          if (s_axi_wvalid) begin
            addr_q <= addr_next;
            beat_q <= beat_q + 9'd1;
            // Beat count, not wlast, closes the burst.
            if (beat_q[7:0] == len_q) begin
              s_axi_bid <= id_q;
              state     <= WRESP;
            end
          end
        end
        WRESP: begin
          if (s_axi_bready) state <= IDLE;
        end
        READ: begin
          if (!s_axi_rvalid || s_axi_rready) begin
            if (beat_q <= {1'b0, len_q}) begin
              s_axi_rvalid <= 1'b1;
              s_axi_rdata  <= mem[idx];
              s_axi_rlast  <= (beat_q[7:0] == len_q);
              addr_q       <= addr_next;
              beat_q       <= beat_q + 9'd1;
            end else begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
            end
            if (s_axi_rvalid && s_axi_rlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave; read data checked through an expected-value queue
// filled from a bench-side memory model. Honours AXI_RAM_WRAP_BURST_EN like the design.
`timescale 1ns/1ps
module tb_axi_ram_slave;
  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp, fsm_state;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
  logic        bvalid, bready = 0, arvalid = 0, arready, rlast, rvalid, rready = 0;

  axi_ram_slave dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready), .fsm_state(fsm_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [int];
  logic [31:0] wbuf [16];

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step;
    step = 32'd1 << size;
    if (burst == 2'b00) return a;
`ifdef AXI_RAM_WRAP_BURST_EN
    if (burst == 2'b10) begin
      logic [31:0] wsize, base;
      wsize = ({24'd0, len} + 32'd1) << size;
      base  = a - (a % wsize);
      return base + ((a - base + step) % wsize);
    end
`endif
    return a + step;
  endfunction

  task automatic reset_dut();
    rstn = 1'b0;
    awvalid = 0; arvalid = 0; wvalid = 0; bready = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---- driver tasks (entered and left at posedge+1) ----
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int waited);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      waited++;
      if (waited > BUDGET) begin
        checks++; errors++;
        $display("FAIL aw_timeout awready got 0 expected 1");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         output int waited, output int n_acc);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    waited = 0;
    n_acc = 0;
    forever begin
      @(negedge clk);
      if (arready) begin
        n_acc = cyc;
        break;
      end
      waited++;
      if (waited > BUDGET) begin
        checks++; errors++;
        $display("FAIL ar_timeout arready got 0 expected 1");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic write_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb);
    logic [31:0] a, old;
    int w;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len));
      w = 0;
      forever begin
        @(negedge clk);
        if (wready) break;
        w++;
        if (w > BUDGET) break;
        @(posedge clk); #1;
      end
      if (i == 0) begin
        checks++;
        if (w !== 0) begin
          errors++;
          $display("FAIL w_ready_latency wait got %0d expected 0", w);
        end
      end
      old = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) old[b*8 +: 8] = wbuf[i][b*8 +: 8];
      model[widx(a)] = old;
      a = tb_next(a, size, len, burst);
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0; bready = 1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL b_latency bvalid got %b expected 1", bvalid);
    end
    w = 0;
    while (bvalid !== 1'b1 && w < BUDGET) begin
      @(posedge clk); #1; @(negedge clk); w++;
    end
    checks++;
    if (bid !== id || bresp !== 2'b00) begin
      errors++;
      $display("FAIL b_fields bid/bresp got %h/%b expected %h/00", bid, bresp, id);
    end
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic read_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                            input int n_acc);
    logic [31:0] a, held, e;
    logic held_l;
    bit held_v, first;
    int beat, guard;
    a = addr; held_v = 0; first = 1; beat = 0; guard = 0; held = '0; held_l = 0;
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(model[widx(a)]);
      a = tb_next(a, size, len, burst);
    end
    while (beat <= int'(len)) begin
      rready = toggle ? guard[0] : 1'b1;
      @(negedge clk);
      if (guard == 0) begin
        checks++;
        if (rvalid !== 1'b0) begin
          errors++;
          $display("FAIL r_early rvalid got %b expected 0", rvalid);
        end
      end
      if (first && rvalid) begin
        first = 0;
        checks++;
        if (cyc !== n_acc + 2) begin
          errors++;
          $display("FAIL r_latency cycle got %0d expected %0d", cyc, n_acc + 2);
        end
      end
      if (rvalid && held_v) begin
        checks++;
        if (rdata !== held || rlast !== held_l) begin
          errors++;
          $display("FAIL r_stall_stable rdata/rlast got %h/%b expected %h/%b", rdata, rlast, held, held_l);
        end
      end
      if (rvalid && rready) begin
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
          errors++;
          $display("FAIL r_data beat %0d got %h expected %h", beat, rdata, e);
        end
        checks++;
        if (rlast !== (beat == int'(len))) begin
          errors++;
          $display("FAIL r_last beat %0d got %b expected %b", beat, rlast, beat == int'(len));
        end
        checks++;
        if (rid !== id || rresp !== 2'b00) begin
          errors++;
          $display("FAIL r_fields rid/rresp got %h/%b expected %h/00", rid, rresp, id);
        end
        beat++;
        held_v = 0;
      end else if (rvalid) begin
        held = rdata; held_l = rlast; held_v = 1;
      end
      guard++;
      if (guard > BUDGET) begin
        checks++; errors++;
        $display("FAIL r_timeout beats got %0d expected %0d", beat, int'(len) + 1);
        exp_q.delete();
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    rready = 0;
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb);
    int w;
    send_aw(id, addr, len, size, burst, w);
    write_phase(id, addr, len, size, burst, strb);
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int w, n;
    send_ar(id, addr, len, size, burst, w, n);
    read_phase(id, addr, len, size, burst, toggle, n);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset_dut();
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000", {awready, wready, arready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({bid, rid, bresp, rresp, rdata} !== 52'h0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_data bid %h rid %h rdata %h state %0d expected zeros", bid, rid, rdata, fsm_state);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEADBEEF;
    write_burst(8'h5A, 32'h10, 8'd0, 3'd2, 2'b01, 4'hF);
    read_burst(8'hA5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    write_burst(8'h01, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF);
    read_burst(8'h02, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'hFFFFFFFF;
    write_burst(8'h03, 32'h20, 8'd0, 3'd2, 2'b01, 4'hF);
    wbuf[0] = 32'h00000000;
    write_burst(8'h04, 32'h20, 8'd0, 3'd2, 2'b01, 4'b0101);
    read_burst(8'h05, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);
  endtask

  // Raise AW and AR together; the winner runs first, the loser is served right after.
  task automatic arb_both(input bit exp_write, input logic [31:0] addr);
    int w, n;
    wbuf[0] = $urandom;
    awid = 8'h11; awaddr = addr; awlen = 0; awsize = 2; awburst = 2'b01;
    arid = 8'h22; araddr = addr; arlen = 0; arsize = 2; arburst = 2'b01;
    awvalid = 1; arvalid = 1;
    @(negedge clk);
    n = cyc;
    checks++;
    if (awready !== exp_write || arready !== !exp_write) begin
      errors++;
      $display("FAIL arb_grant awready/arready got %b/%b expected %b/%b", awready, arready, exp_write, !exp_write);
      @(posedge clk); #1;
      reset_dut();
      return;
    end
    @(posedge clk); #1;
    if (exp_write) begin
      awvalid = 0;
      write_phase(8'h11, addr, 8'd0, 3'd2, 2'b01, 4'hF);
      send_ar(8'h22, addr, 8'd0, 3'd2, 2'b01, w, n);
      read_phase(8'h22, addr, 8'd0, 3'd2, 2'b01, 1'b0, n);
    end else begin
      arvalid = 0;
      read_phase(8'h22, addr, 8'd0, 3'd2, 2'b01, 1'b0, n);
      send_aw(8'h11, addr, 8'd0, 3'd2, 2'b01, w);
      write_phase(8'h11, addr, 8'd0, 3'd2, 2'b01, 4'hF);
    end
  endtask

  task automatic test_arbitration();
    reset_dut();
    arb_both(1'b1, 32'h200);
    arb_both(1'b1, 32'h204);
    wbuf[0] = 32'h13579BDF;
    write_burst(8'h06, 32'h208, 8'd0, 3'd2, 2'b01, 4'hF);
    arb_both(1'b0, 32'h208);
  endtask

  task automatic test_back_to_back();
    int w, n;
    wbuf[0] = $urandom;
    write_burst(8'h07, 32'h300, 8'd0, 3'd2, 2'b01, 4'hF);
    send_ar(8'h08, 32'h300, 8'd0, 3'd2, 2'b01, w, n);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL b2b_read_accept wait got %0d expected 0", w);
    end
    read_phase(8'h08, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0, n);
    wbuf[0] = $urandom;
    send_aw(8'h09, 32'h304, 8'd0, 3'd2, 2'b01, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL b2b_write_accept wait got %0d expected 0", w);
    end
    write_phase(8'h09, 32'h304, 8'd0, 3'd2, 2'b01, 4'hF);
  endtask

  task automatic test_fixed();
    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002;
    write_burst(8'h0A, 32'h400, 8'd1, 3'd2, 2'b00, 4'hF);
    read_burst(8'h0B, 32'h400, 8'd1, 3'd2, 2'b00, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) wbuf[i] = 32'h0;
    write_burst(8'h0C, 32'h30, 8'd5, 3'd2, 2'b01, 4'hF);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
    write_burst(8'h0D, 32'h38, 8'd3, 3'd2, 2'b10, 4'hF);
    read_burst(8'h0E, 32'h30, 8'd5, 3'd2, 2'b01, 1'b0);
    read_burst(8'h0F, 32'h38, 8'd3, 3'd2, 2'b10, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    int w, n;
    logic [31:0] e;
    e = model[widx(32'h100)];
    send_ar(8'h33, 32'h100, 8'd3, 3'd2, 2'b01, w, n);
    rready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      errors++;
      $display("FAIL mid_read_beat0 rvalid/rdata got %b/%h expected 1/%h", rvalid, rdata, e);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rready = 0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_read_reset rvalid/rlast/state got %b/%b/%0d expected 0/0/0", rvalid, rlast, fsm_state);
    end
    @(posedge clk); #1;
    read_burst(8'h34, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe();
    test_arbitration();
    test_back_to_back();
    test_fixed();
    test_wrap();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain left got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time got %0t expected under 500000", $time);
    $fatal(1, "watchdog");
  end
endmodule
